wb_master_bridge: RTL
=====================

Name: wb_master_bridge

Overview:
- Classic (non-pipelined) Wishbone initiator that turns a single-beat valid/ready command stream into Wishbone bus cycles. It returns each result on a valid/ready response stream.
- Drives the initiator side of Wishbone responders such as the team's Wishbone RAM test model. It is used in test benches and simple peripheral bridges.
- Handles one outstanding transaction at a time and includes an optional bus timeout.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 16, byte address width in bits.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 256, maximum cycles with cyc_o high before the block aborts the cycle. 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  ADDR_WIDTH  byte address.
- cmd_dat  input  DATA_WIDTH  write data.
- cmd_sel  input  SELECT_WIDTH  byte enables.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_dat  output  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  output  1  cycle ended with err_i or a timeout.
- rsp_timeout  output  1  cycle ended by timeout.
- adr_o  output  ADDR_WIDTH  Wishbone ADR_O.
- dat_o  output  DATA_WIDTH  Wishbone DAT_O.
- dat_i  input  DATA_WIDTH  Wishbone DAT_I.
- we_o  output  1  Wishbone WE_O.
- sel_o  output  SELECT_WIDTH  Wishbone SEL_O.
- stb_o  output  1  Wishbone STB_O.
- cyc_o  output  1  Wishbone CYC_O.
- ack_i  input  1  Wishbone ACK_I.
- err_i  input  1  Wishbone ERR_I.

Behaviour:

Reset values:
- State = IDLE.
- cyc_o, stb_o, we_o, rsp_valid, rsp_err and rsp_timeout are 0.
- adr_o, dat_o, sel_o and rsp_dat are 0.
- The timeout counter is 0.

Outputs are registered, except cmd_ready, which is 1 exactly when state = IDLE and rst = 0.

IDLE state:
- On cmd_valid & cmd_ready, the block latches we, adr, dat and sel into the bus output registers.
- It sets cyc_o = stb_o = 1 and moves to BUS.
- The bus cycle starts in the cycle after acceptance.

BUS state:
- adr_o, dat_o, we_o and sel_o stay stable, and cyc_o and stb_o stay high, until termination.
- The counter increments each cycle.
- Termination is evaluated at each rising edge, in this priority order:
  1. err_i: rsp_err = 1, rsp_timeout = 0, rsp_dat = 0.
  2. ack_i: rsp_err = 0. rsp_dat = dat_i if we_o = 0, else 0.
  3. Counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: rsp_err = 1, rsp_timeout = 1, rsp_dat = 0.
- If ack_i and err_i are high together, err wins.
- On termination, cyc_o and stb_o go to 0 on the same edge, rsp_valid goes to 1, the counter clears, and state moves to RESP.
- cyc_o therefore never stays high in the cycle after ack is sampled. This is compatible with responders that guard with ~ack.

RESP state:
- rsp_valid, rsp_dat, rsp_err and rsp_timeout are held stable.
- On rsp_ready, rsp_valid drops, the other response fields clear to 0, and state returns to IDLE.
- A new command can be accepted no earlier than the cycle after the response handshake. There is no bypass.

Latency:
- Accept at edge E0; stb_o is high in cycle 1.
- A zero-wait responder that registers ack asserts it in cycle 2; the block samples it at E2.
- rsp_valid is high in cycle 3, so accept-to-response is 3 cycles.
- Each responder wait state adds 1 cycle.
- Back-to-back throughput is one transaction per 4 cycles when rsp_ready is held at 1.

Other rules:
- A timeout fires after exactly TIMEOUT_CYCLES cycles with cyc_o high.
- ack_i or err_i arriving outside BUS is ignored.
- Reset in any state, including mid-cycle: cyc_o and stb_o are 0 in the next cycle, any pending response is discarded, and state returns to IDLE.
- cmd_* inputs are ignored while not in IDLE.

Test Plan:
- Write then read, against a Wishbone RAM responder (DATA_WIDTH 32):
  - Write adr 0x0010, dat 0xDEADBEEF, sel 0xF -> rsp_err 0, rsp_dat 0.
  - Read 0x0010 -> rsp_dat 0xDEADBEEF.
  - rsp_valid 3 cycles after each accept.
- Partial write: sel 0x2, dat 0x0000AB00 to 0x0010, then read 0x0010 -> 0xDEADABEF.
- Error: responder asserts err_i and ack_i together in the 2nd bus cycle -> rsp_err 1, rsp_timeout 0, rsp_dat 0, cyc_o low on the next cycle.
- Timeout: TIMEOUT_CYCLES 8, responder never acks -> cyc_o high for exactly 8 cycles, then rsp_err 1, rsp_timeout 1.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready 0 throughout; rsp_ready 1 -> cmd_ready 1 in the following cycle.
- Reset mid-cycle: assert rst in the 1st cycle of BUS -> cyc_o and stb_o 0 in the next cycle, no rsp_valid; the next read completes normally.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Classic Wishbone initiator: one valid/ready command becomes one bus cycle,
// and the result comes back on a valid/ready response stream. Optional bus timeout.
module wb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    // Both streams: a transfer happens on a rising edge where valid && ready;
    // a producer holds its payload stable while valid is high and ready is low.
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // A zero timeout would give a zero-width counter; keep one bit so it still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    bus_q, bus_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_to_q, rsp_to_d;

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign cyc_o       = bus_q;
    assign stb_o       = bus_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        sel_d       = sel_q;
        bus_d       = bus_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    bus_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + 1'b1;
                // err has priority over ack, and both over the timeout.
                if (err_i || ack_i || (TIMEOUT_EN && cnt_q == CNT_LAST)) begin
                    bus_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RESP;
                    if (err_i) begin
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b0;
                        rsp_dat_d = '0;
                    end else if (ack_i) begin
                        rsp_err_d = 1'b0;
                        rsp_to_d  = 1'b0;
                        rsp_dat_d = we_q ? '0 : dat_i;
                    end else begin
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b1;
                        rsp_dat_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                bus_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            bus_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            bus_q       <= bus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

endmodule
